wb_vmon_msg_arbiter: RTL and testbench

- Shares one vmon Wishbone monitor endpoint between N message producers.
- Each producer streams message bytes over a valid/ready/last interface.
- The arbiter grants round-robin, holds the grant for a whole message, and packs bytes into 32-bit Wishbone writes to ADDRESS.
- Writes use only the SEL patterns the monitor accepts. It sits between HDL-side message sources and the wb_vmon monitor's bus.

---
 rtl/wb_vmon_msg_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wb_vmon_msg_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_vmon_msg_arbiter.sv
// Round-robin arbiter packing N byte streams into 32-bit Wishbone writes to one vmon monitor address.
// Latency: grant 1 cycle after valid seen in IDLE; write issued the cycle after the 4th or last byte.
// Backpressure: ready only to the owner while collecting or draining; bus stalls until ACK/ERR/timeout.
module wb_vmon_msg_arbiter #(
    parameter int                       N_REQ         = 4,
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS       = '0,
    parameter int                       TIMEOUT       = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           grant_o,
    output logic [WB_ADDR_WIDTH-1:0]   ADR,
    output logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH/8-1:0] SEL,
    output logic                       CYC,
    output logic                       STB,
    output logic                       WE,
    input  logic                       ACK,
    input  logic                       ERR,
    output logic                       busy_o,
    output logic                       err_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_WRITE2, S_DRAIN} state_t;

    state_t                   r_state, w_state_nxt;
    logic [IW-1:0]            r_rr, r_gidx, w_pick, w_rr_nxt;
    logic [N_REQ-1:0]         r_grant;
    logic [2:0]               r_cnt;
    logic [WB_DATA_WIDTH-1:0] r_data;
    logic                     r_done, r_err;
    logic [TW-1:0]            r_tmo;
    logic                     w_any, w_vld, w_lst, w_acc, w_tmo, w_fail;
    logic [7:0]               w_byte;
    int                       w_sum;

    // First valid requester at or after the rr pointer; descending scan lets the nearest win.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_sum  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = int'(r_rr) + k;
            if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
            if (req_valid[w_sum[IW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_sum[IW-1:0];
            end
        end
    end

    assign w_rr_nxt = (w_pick == IW'(N_REQ - 1)) ? '0 : w_pick + 1'b1;
    assign w_vld    = req_valid[r_gidx];
    assign w_lst    = req_last[r_gidx];
    assign w_byte   = req_data[{r_gidx, 3'b000} +: 8];
    assign w_acc    = (r_state == S_COLLECT) && (r_cnt < 3'd4) && w_vld;
    assign w_tmo    = (r_tmo == TW'(TIMEOUT - 1));
    assign w_fail   = ERR || w_tmo;

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        CYC         = 1'b0;
        SEL         = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                req_ready[r_gidx] = (r_cnt < 3'd4);
                if (w_acc && (w_lst || r_cnt == 3'd3)) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                CYC = 1'b1;
                case (r_cnt)
                    3'd1:       SEL = 4'b0001;
                    3'd2, 3'd3: SEL = 4'b0011;
                    default:    SEL = 4'b1111;
                endcase
                if (w_fail)             w_state_nxt = r_done ? S_IDLE : S_DRAIN;
                else if (ACK) begin
                    if (r_cnt == 3'd3)  w_state_nxt = S_WRITE2;
                    else                w_state_nxt = r_done ? S_IDLE : S_COLLECT;
                end
            end
            S_WRITE2: begin
                CYC = 1'b1;
                SEL = 4'b0100;
                if (w_fail)   w_state_nxt = r_done ? S_IDLE : S_DRAIN;
                else if (ACK) w_state_nxt = r_done ? S_IDLE : S_COLLECT;
            end
            S_DRAIN: begin
                req_ready[r_gidx] = 1'b1;
                if (w_vld && w_lst) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_gidx  <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= '0;
            if (r_state != S_IDLE && w_state_nxt == S_IDLE) r_grant <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gidx  <= w_pick;
                        r_grant <= N_REQ'(1) << w_pick;
                        r_rr    <= w_rr_nxt;
                        r_cnt   <= '0;
                        r_data  <= '0;
                        r_done  <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (w_acc) begin
                        r_data[{r_cnt[1:0], 3'b000} +: 8] <= w_byte;
                        r_cnt <= r_cnt + 3'd1;
                        if (w_lst) r_done <= 1'b1;
                    end
                end
                S_WRITE, S_WRITE2: begin
                    if (w_fail) r_err <= 1'b1;
                    if (w_state_nxt == r_state) r_tmo <= r_tmo + 1'b1;
                    // Buffer survives only the split 3-byte write, whose lane 2 is still pending.
                    if (w_state_nxt != r_state && w_state_nxt != S_WRITE2) begin
                        r_cnt  <= '0;
                        r_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant_o = r_grant;
    assign ADR     = CYC ? ADDRESS : '0;
    assign STB     = CYC;
    assign WE      = CYC;
    assign DAT_W   = r_data;
    assign busy_o  = (r_state != S_IDLE);
    assign err_o   = r_err;
endmodule

// File: tb/tb_wb_vmon_msg_arbiter.sv
// Bench for wb_vmon_msg_arbiter: random byte streams against a message-level write model.
module tb_wb_vmon_msg_arbiter;
    localparam logic [31:0] ADDR = 32'hA000_0040;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  req_valid = '0, req_last = '0, req_ready, grant_o;
    logic [31:0] req_data = '0, ADR, DAT_W;
    logic [3:0]  SEL;
    logic        CYC, STB, WE, busy_o, err_o;
    logic        ACK = 1'b0, ERR = 1'b0;

    wb_vmon_msg_arbiter #(.N_REQ(4), .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32),
                          .ADDRESS(ADDR), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant_o(grant_o), .ADR(ADR),
        .DAT_W(DAT_W), .SEL(SEL), .CYC(CYC), .STB(STB), .WE(WE), .ACK(ACK), .ERR(ERR),
        .busy_o(busy_o), .err_o(err_o));

    always #5 clk_i = ~clk_i;

    typedef struct { int g; logic [3:0] sel; logic [31:0] dat; } wr_t;
    wr_t        exp_q[$];
    logic [8:0] q [4][$];
    logic [3:0] acc, mid = '0;
    int         n_chk = 0, n_err = 0;
    int         m_rr = 0;
    int         s_mode = 0, s_cnt = 0, s_dly = 0, s_max = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_w(input int g, input logic [3:0] sel, input logic [31:0] dat);
        wr_t w;
        w.g = g; w.sel = sel; w.dat = dat;
        exp_q.push_back(w);
    endtask

    task automatic add_byte(input int r, input logic [7:0] b, input logic last);
        q[r].push_back({last, b});
    endtask

    // Whole-message view: owner order from the rr rule, bytes chopped into 4-byte words.
    task automatic model_run();
        int         rd[4], left[4];
        logic [7:0] b[$];
        int         g, n;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0; left[i] = 0;
            for (int k = 0; k < q[i].size(); k++) if (q[i][k][8]) left[i]++;
        end
        while (1) begin
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && left[(m_rr + k) % 4] > 0) g = (m_rr + k) % 4;
            if (g < 0) break;
            m_rr = (g + 1) % 4;
            left[g]--;
            b.delete();
            do begin
                b.push_back(q[g][rd[g]][7:0]);
                rd[g]++;
            end while (!q[g][rd[g]-1][8]);
            for (int s = 0; s < b.size(); s += 4) begin
                n = b.size() - s;
                if (n > 4) n = 4;
                case (n)
                    4: push_w(g, 4'hF, {b[s+3], b[s+2], b[s+1], b[s]});
                    3: begin
                        push_w(g, 4'h3, {16'h0, b[s+1], b[s]});
                        push_w(g, 4'h4, {8'h0, b[s+2], 16'h0});
                    end
                    2: push_w(g, 4'h3, {16'h0, b[s+1], b[s]});
                    default: push_w(g, 4'h1, {24'h0, b[s]});
                endcase
            end
        end
    endtask

    task automatic record();
        wr_t         e;
        logic [31:0] mask;
        if (exp_q.size() == 0) begin
            chk("wr_unexpected_qdepth", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int l = 0; l < 4; l++) mask[8*l +: 8] = {8{e.sel[l]}};
        chk("wr_grant", {28'h0, grant_o}, 32'(4'b0001 << e.g));
        chk("wr_sel", {28'h0, SEL}, {28'h0, e.sel});
        chk("wr_dat", DAT_W & mask, e.dat);
        chk("wr_adr", ADR, ADDR);
        chk("wr_stb_we", {30'h0, STB, WE}, 32'h3);
    endtask

    // One clock: sample/drive slave at negedge, advance requesters just after posedge.
    task automatic step();
        @(negedge clk_i);
        acc = req_valid & req_ready;
        if (ACK || ERR) begin
            ACK = 1'b0; ERR = 1'b0; s_cnt = 0;
            s_dly = $urandom_range(0, s_max);
        end else if (CYC) begin
            if (s_mode == 0 && s_cnt >= s_dly) begin
                ACK = 1'b1;
                record();
            end else if (s_mode == 2 && s_cnt >= s_dly) begin
                ACK = 1'b1; ERR = 1'b1;
            end else s_cnt++;
        end
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && q[i].size() > 0) begin
                mid[i] = !q[i][0][8];
                q[i].delete(0);
            end
            if (q[i].size() > 0) begin
                req_data[8*i +: 8] = q[i][0][7:0];
                req_last[i]        = q[i][0][8];
                req_valid[i]       = mid[i] ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic run_until_done(input int budget);
        int c = 0;
        while (c < budget && !(exp_q.size() == 0 && !busy_o && !CYC &&
               q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0)) begin
            step();
            c++;
        end
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        chk("end_busy", {31'h0, busy_o}, 32'd0);
        chk("end_grant", {28'h0, grant_o}, 32'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, {28'h0, req_ready}, 32'd0);
        chk({tag, "_grant"}, {28'h0, grant_o}, 32'd0);
        chk({tag, "_adr"}, ADR, 32'd0);
        chk({tag, "_dat"}, DAT_W, 32'd0);
        chk({tag, "_sel_cyc_stb_we"}, {25'h0, SEL, CYC, STB, WE}, 32'd0);
        chk({tag, "_busy_err"}, {30'h0, busy_o, err_o}, 32'd0);
    endtask

    initial begin
        int n, tr, tn, nm, len;
        // Reset holds everything quiet even with all requesters asking.
        req_valid = 4'hF;
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        req_valid = '0;
        rst_i = 1'b0;

        // All four ask with 1-byte messages; requester 0 has a second one.
        add_byte(0, 8'h10, 1); add_byte(0, 8'h50, 1);
        add_byte(1, 8'h21, 1); add_byte(2, 8'h32, 1); add_byte(3, 8'h43, 1);
        model_run(); run_until_done(200);
        add_byte(0, 8'h11, 0); add_byte(0, 8'h22, 0); add_byte(0, 8'h33, 0); add_byte(0, 8'h44, 1);
        model_run(); run_until_done(200);
        add_byte(1, 8'hA1, 0); add_byte(1, 8'hB2, 0); add_byte(1, 8'hC3, 1);
        model_run(); run_until_done(200);
        for (int k = 1; k <= 6; k++) add_byte(2, 8'(k), k == 6);
        model_run(); run_until_done(200);

        s_max = 3;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) begin
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 9);
                    for (int k = 0; k < len; k++) add_byte(i, 8'($urandom), k == len - 1);
                end
            end
            model_run(); run_until_done(3000);
        end
        s_max = 0;

        // Silent slave: 6-byte message times out, tail drained, next owner served.
        tr = m_rr; tn = (m_rr + 1) % 4;
        for (int k = 0; k < 6; k++) add_byte(tr, 8'(8'h60 + k), k == 5);
        add_byte(tn, 8'h77, 1);
        push_w(tn, 4'h1, 32'h77);
        m_rr = (tn + 1) % 4;
        s_mode = 1;
        n = 0;
        while (!CYC && n < 60) begin step(); n++; end
        chk("tmo_cyc_seen", {31'h0, CYC}, 32'd1);
        n = 0;
        while (CYC && n < 40) begin step(); n++; end
        chk("tmo_cyc_len", 32'(n), 32'd8);
        chk("tmo_err", {31'h0, err_o}, 32'd1);
        s_mode = 0;
        run_until_done(300);
        chk("err_sticky", {31'h0, err_o}, 32'd1);

        // Reset mid-write, then arbitration restarts from requester 0.
        s_mode = 1;
        for (int k = 0; k < 4; k++) add_byte(2, 8'(8'h80 + k), k == 3);
        n = 0;
        while (!CYC && n < 60) begin step(); n++; end
        chk("rst_cyc_seen", {31'h0, CYC}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_all_zero("rst_inflight");
        for (int i = 0; i < 4; i++) q[i].delete();
        mid = '0; req_valid = '0; req_last = '0;
        ACK = 1'b0; ERR = 1'b0; s_cnt = 0; s_mode = 0;
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_rr = 0;
        add_byte(3, 8'h33, 1); add_byte(0, 8'hC0, 1);
        model_run(); run_until_done(200);

        // ACK together with ERR counts as an error and completes nothing.
        chk("err_before", {31'h0, err_o}, 32'd0);
        s_mode = 2;
        add_byte(1, 8'h5A, 0); add_byte(1, 8'hA5, 1);
        m_rr = 2;
        run_until_done(200);
        chk("err_after", {31'h0, err_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
